// File: rtl/alu_pkg.sv
// Shared ALU package: state encoding and default datapath width.
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

endpackage : alu_pkg

// File: rtl/seq_mul.sv
// Sequential shift-and-add unsigned multiplier: one partial product per clock,
// WIDTH iterations, then a one-cycle done strobe with the 2*WIDTH-bit product.
module seq_mul
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH + 1);

  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  // P[2W] holds the adder carry; the multiplier bits drain out the bottom.
  logic [2*WIDTH:0]   p_q, p_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;

  logic [WIDTH:0]     upper_sum;
  logic [WIDTH:0]     upper_sel;
  logic [2*WIDTH:0]   p_step;
  logic               accept;

  // One iteration: conditional add into the upper half, then shift right.
  always_comb begin
    upper_sum = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    upper_sel = p_q[0] ? upper_sum : p_q[2*WIDTH:WIDTH];
    p_step    = {1'b0, upper_sel, p_q[WIDTH-1:1]};
  end

  // Next-state and datapath control; start is only honoured in IDLE or DONE.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          accept  = 1'b1;
          state_d = ST_RUN;
          mcand_d = a;
          p_d     = {{(WIDTH+1){1'b0}}, b};
          cnt_d   = CW'(WIDTH);
        end
      end
      ST_RUN: begin
        p_d   = p_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_DONE;
          prod_d  = p_step[2*WIDTH-1:0];
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mcand_q <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = prod_q;

endmodule : seq_mul

// File: tb/tb_seq_mul.sv
// Directed self-checking bench for seq_mul (WIDTH=4).
module tb_seq_mul;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] product;

  int nvec = 0;
  int nerr = 0;

  seq_mul #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .product(product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are observed 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Single operation with full latency/strobe checking.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input int exp);
    a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < W; i++) begin
      chk("run_busy", 32'(busy), 32'd1);
      chk("run_done", 32'(done), 32'd0);
      tick();
    end
    chk("done_hi", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("product", 32'(product), 32'(exp));
    tick();
    chk("done_pulse", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("prod_hold", 32'(product), 32'(exp));
  endtask

  initial begin
    int ndone;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_prod", 32'(product), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_busy0", 32'(busy), 32'd0);
    chk("idle_done0", 32'(done), 32'd0);

    run_op(4'd7, 4'd3, 21);
    run_op(4'd15, 4'd15, 225);
    run_op(4'd0, 4'd9, 0);
    run_op(4'd9, 4'd0, 0);

    // start during RUN must be ignored
    a = 4'd11; b = 4'd13; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 4'd2; b = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_busy", 32'(busy), 32'd1);
    tick(); tick();
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_prod", 32'(product), 32'd143);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (done) ndone++;
    end
    chk("ign_extra_done", 32'(ndone), 32'd0);
    chk("ign_prod_hold", 32'(product), 32'd143);

    // start held high: back-to-back operations
    a = 4'd5; b = 4'd6; start = 1'b1;
    tick();
    for (int i = 0; i < W; i++) tick();
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_prod1", 32'(product), 32'd30);
    a = 4'd3; b = 4'd4;
    tick();
    chk("b2b_busy", 32'(busy), 32'd1);
    chk("b2b_done_lo", 32'(done), 32'd0);
    chk("b2b_prod_keep", 32'(product), 32'd30);
    for (int i = 0; i < W; i++) tick();
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_prod2", 32'(product), 32'd12);
    start = 1'b0;
    tick();
    chk("b2b_idle", 32'(busy), 32'd0);

    // reset during the 3rd RUN cycle of 9*9
    a = 4'd9; b = 4'd9; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("mid_busy", 32'(busy), 32'd1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_prod", 32'(product), 32'd0);
    ndone = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done || busy) ndone++;
    end
    chk("mrst_quiet", 32'(ndone), 32'd0);
    run_op(4'd9, 4'd9, 81);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_seq_mul
